// File: rtl/melody_sequencer.sv
// rtl/melody_sequencer.sv - table-driven note scheduler feeding the buzzer square-wave toggler
// Define MELODY_GAP_EN to insert GAP_TICKS silent ticks after every sounding note.
module melody_sequencer #(
  parameter int DEPTH     = 16,
  parameter int TICK_DIV  = 500000,
  parameter int GAP_TICKS = 2,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic          mclk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stop,
  input  logic          loop_en,
  input  logic [AW-1:0] last_idx,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [27:0]   wr_data,
  output logic [19:0]   half_period,
  output logic          tone_on,
  output logic [AW-1:0] note_idx,
  output logic          busy,
  output logic          done
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two of at least 2");
  end
  if (TICK_DIV < 1) begin : g_bad_tick_div
    $error("TICK_DIV must be at least 1");
  end
  if (GAP_TICKS < 1 || GAP_TICKS > 256) begin : g_bad_gap_ticks
    $error("GAP_TICKS must be in 1..256");
  end

`ifdef MELODY_GAP_EN
  localparam logic [7:0] GAP_LOAD = 8'(GAP_TICKS - 1);
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_PLAY, S_GAP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_PLAY} state_t;
`endif

  state_t          state, state_n;
  logic [PW-1:0]   presc, presc_n, presc_cnt;
  logic [7:0]      ticks, ticks_n, ticks_cnt;
  logic [19:0]     hp_n;
  logic            tone_n, busy_n, done_n;
  logic [AW-1:0]   idx_n;
  logic            advance, tick_end;

  logic [27:0]     table_mem [DEPTH];
  logic [19:0]     ent_hp;
  logic [7:0]      ent_dur;

  // Read uses the pre-edge contents, so a write during FETCH lands for the next fetch.
  always_ff @(posedge mclk) begin
    if (wr_en) begin
      table_mem[wr_addr] <= wr_data;
    end
  end

  assign ent_hp  = table_mem[note_idx][27:8];
  assign ent_dur = table_mem[note_idx][7:0];

  always_ff @(posedge mclk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      presc       <= '0;
      ticks       <= '0;
      half_period <= '0;
      tone_on     <= 1'b0;
      note_idx    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_n;
      presc       <= presc_n;
      ticks       <= ticks_n;
      half_period <= hp_n;
      tone_on     <= tone_n;
      note_idx    <= idx_n;
      busy        <= busy_n;
      done        <= done_n;
    end
  end

  always_comb begin
    state_n  = state;
    presc_n  = presc;
    ticks_n  = ticks;
    hp_n     = half_period;
    tone_n   = tone_on;
    idx_n    = note_idx;
    done_n   = 1'b0;
    advance  = 1'b0;
    tick_end = (presc == '0) && (ticks == 8'd0);

    // Shared duration timebase: prescaler wraps every TICK_DIV cycles, then a tick is consumed.
    if (presc == '0) begin
      presc_cnt = PRESC_MAX;
      ticks_cnt = ticks - 8'd1;
    end else begin
      presc_cnt = presc - 1'b1;
      ticks_cnt = ticks;
    end

    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_FETCH;
          idx_n   = '0;
        end
      end
      S_FETCH: begin
        if (ent_dur == 8'd0) begin
          advance = 1'b1;
        end else begin
          state_n = S_PLAY;
          presc_n = PRESC_MAX;
          ticks_n = ent_dur - 8'd1;
          hp_n    = ent_hp;
          tone_n  = (ent_hp != 20'd0);
        end
      end
      S_PLAY: begin
        if (tick_end) begin
          tone_n = 1'b0;
`ifdef MELODY_GAP_EN
          if (half_period != 20'd0) begin
            state_n = S_GAP;
            presc_n = PRESC_MAX;
            ticks_n = GAP_LOAD;
          end else begin
            advance = 1'b1;
          end
`else
          advance = 1'b1;
`endif
        end else begin
          presc_n = presc_cnt;
          ticks_n = ticks_cnt;
        end
      end
`ifdef MELODY_GAP_EN
      S_GAP: begin
        if (tick_end) begin
          advance = 1'b1;
        end else begin
          presc_n = presc_cnt;
          ticks_n = ticks_cnt;
        end
      end
`endif
      default: state_n = S_IDLE;
    endcase

    if (advance) begin
      tone_n = 1'b0;
      if (note_idx != last_idx) begin
        idx_n   = note_idx + 1'b1;
        state_n = S_FETCH;
      end else if (loop_en) begin
        idx_n   = '0;
        state_n = S_FETCH;
      end else begin
        state_n = S_IDLE;
        done_n  = 1'b1;
      end
    end

    if (stop) begin
      state_n = S_IDLE;
      tone_n  = 1'b0;
      done_n  = 1'b0;
    end

    busy_n = (state_n != S_IDLE);
  end

endmodule

// File: tb/tb_melody_sequencer.sv
// tb/tb_melody_sequencer.sv - scoreboard bench for melody_sequencer (TICK_DIV=4, DEPTH=16)
// Expected per-cycle outputs are queued with the stimulus and popped one per clock.
module tb_melody_sequencer;

  localparam int TD = 4;
`ifdef MELODY_GAP_EN
  localparam int GAP_CYC = 2 * TD;
`else
  localparam int GAP_CYC = 0;
`endif

  logic        mclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        loop_en = 1'b0;
  logic [3:0]  last_idx = '0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [27:0] wr_data = '0;
  logic [19:0] half_period;
  logic        tone_on;
  logic [3:0]  note_idx;
  logic        busy;
  logic        done;

  melody_sequencer #(.DEPTH(16), .TICK_DIV(TD), .GAP_TICKS(2)) dut (
    .mclk(mclk), .rst_n(rst_n), .start(start), .stop(stop), .loop_en(loop_en),
    .last_idx(last_idx), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .half_period(half_period), .tone_on(tone_on), .note_idx(note_idx),
    .busy(busy), .done(done)
  );

  always #5 mclk = ~mclk;

  typedef struct {
    logic        tone;
    logic [19:0] hp;
    logic        chk;
    logic [3:0]  idx;
    logic        bsy;
    logic        dn;
  } exp_t;

  exp_t  sb[$];
  int    n_cmp = 0;
  int    n_err = 0;
  string phase = "reset";

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s/%s: got %0d expected %0d at %0t", phase, tag, obs, exp, $time);
    end
  endtask

  task automatic push(input int n, input logic tone, input logic [19:0] hp, input logic chk,
                      input logic [3:0] idx, input logic bsy, input logic dn);
    exp_t e;
    e.tone = tone; e.hp = hp; e.chk = chk; e.idx = idx; e.bsy = bsy; e.dn = dn;
    for (int i = 0; i < n; i++) sb.push_back(e);
  endtask

  // One table entry: FETCH (previous pitch held), PLAY, optional gap after a sounding note.
  task automatic push_note(input logic [19:0] prev_hp, input logic [19:0] hp, input int dur,
                           input logic [3:0] idx);
    push(1, 1'b0, prev_hp, 1'b1, idx, 1'b1, 1'b0);
    push(dur * TD, (hp != 20'd0), hp, 1'b1, idx, 1'b1, 1'b0);
    if (hp != 20'd0 && dur != 0) push(GAP_CYC, 1'b0, hp, 1'b1, idx, 1'b1, 1'b0);
  endtask

  task automatic push_done(input logic [19:0] hp, input logic [3:0] idx);
    push(1, 1'b0, hp, 1'b1, idx, 1'b0, 1'b1);
    push(1, 1'b0, hp, 1'b1, idx, 1'b0, 1'b0);
  endtask

  task automatic run();
    exp_t e;
    while (sb.size() != 0) begin
      @(posedge mclk); #1;
      start = 1'b0;
      stop  = 1'b0;
      wr_en = 1'b0;
      e = sb.pop_front();
      check("tone_on", 32'(tone_on), 32'(e.tone));
      check("busy", 32'(busy), 32'(e.bsy));
      check("done", 32'(done), 32'(e.dn));
      if (e.chk) begin
        check("half_period", 32'(half_period), 32'(e.hp));
        check("note_idx", 32'(note_idx), 32'(e.idx));
      end
    end
  endtask

  task automatic wr_entry(input logic [3:0] addr, input logic [19:0] hp, input logic [7:0] dur);
    wr_en = 1'b1; wr_addr = addr; wr_data = {hp, dur};
    @(posedge mclk); #1;
    wr_en = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge mclk);
    #1;
    check("rst_half_period", 32'(half_period), 32'd0);
    check("rst_tone_on", 32'(tone_on), 32'd0);
    check("rst_note_idx", 32'(note_idx), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;

    phase = "basic";
    wr_entry(4'd0, 20'd1000, 8'd2);
    wr_entry(4'd1, 20'd1500, 8'd1);
    last_idx = 4'd1; loop_en = 1'b0; start = 1'b1;
    push_note(20'd0, 20'd1000, 2, 4'd0);
    push_note(20'd1000, 20'd1500, 1, 4'd1);
    push_done(20'd1500, 4'd1);
    run();

    phase = "rest_skip";
    wr_entry(4'd1, 20'd0, 8'd3);
    wr_entry(4'd2, 20'h12345, 8'd0);
    last_idx = 4'd2; start = 1'b1;
    push_note(20'd1500, 20'd1000, 2, 4'd0);
    push_note(20'd1000, 20'd0, 3, 4'd1);
    push_note(20'd0, 20'h12345, 0, 4'd2);
    push_done(20'd0, 4'd2);
    run();

    phase = "loop";
    wr_entry(4'd1, 20'd1500, 8'd1);
    last_idx = 4'd1; loop_en = 1'b1; start = 1'b1;
    push_note(20'd0, 20'd1000, 2, 4'd0);
    push_note(20'd1000, 20'd1500, 1, 4'd1);
    push_note(20'd1500, 20'd1000, 2, 4'd0);
    push(1, 1'b0, 20'd1000, 1'b1, 4'd1, 1'b1, 1'b0);
    run();
    phase = "collision";
    wr_en = 1'b1; wr_addr = 4'd1; wr_data = {20'd1700, 8'd1};
    push(TD, 1'b1, 20'd1500, 1'b1, 4'd1, 1'b1, 1'b0);
    push(GAP_CYC, 1'b0, 20'd1500, 1'b1, 4'd1, 1'b1, 1'b0);
    push_note(20'd1500, 20'd1000, 2, 4'd0);
    push(1, 1'b0, 20'd1000, 1'b1, 4'd1, 1'b1, 1'b0);
    push(2, 1'b1, 20'd1700, 1'b1, 4'd1, 1'b1, 1'b0);
    run();
    phase = "loop_clear";
    loop_en = 1'b0;
    push(TD - 2, 1'b1, 20'd1700, 1'b1, 4'd1, 1'b1, 1'b0);
    push(GAP_CYC, 1'b0, 20'd1700, 1'b1, 4'd1, 1'b1, 1'b0);
    push_done(20'd1700, 4'd1);
    run();

    phase = "gap";
    wr_entry(4'd0, 20'd800, 8'd1);
    wr_entry(4'd1, 20'd900, 8'd1);
    last_idx = 4'd1; start = 1'b1;
    push_note(20'd1700, 20'd800, 1, 4'd0);
    push_note(20'd800, 20'd900, 1, 4'd1);
    push_done(20'd900, 4'd1);
    run();

    phase = "stop";
    wr_entry(4'd0, 20'd1000, 8'd2);
    start = 1'b1;
    push(1, 1'b0, 20'd900, 1'b1, 4'd0, 1'b1, 1'b0);
    push(3, 1'b1, 20'd1000, 1'b1, 4'd0, 1'b1, 1'b0);
    run();
    stop = 1'b1;
    push(6, 1'b0, 20'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    run();
    phase = "stop_start";
    start = 1'b1; stop = 1'b1;
    push(3, 1'b0, 20'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    run();

    phase = "reset_mid";
    start = 1'b1;
    push(1, 1'b0, 20'd0, 1'b0, 4'd0, 1'b1, 1'b0);
    push(2, 1'b1, 20'd1000, 1'b1, 4'd0, 1'b1, 1'b0);
    run();
    rst_n = 1'b0;
    push(1, 1'b0, 20'd0, 1'b1, 4'd0, 1'b0, 1'b0);
    run();
    rst_n = 1'b1;
    push(2, 1'b0, 20'd0, 1'b1, 4'd0, 1'b0, 1'b0);
    run();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
